fc_neuron_sequencer: RTL and testbench

Sequences a single shared FC neuron (8 pooled pixels × 8-bit weights, registered 8-bit result) across NUM_NEURONS output neurons of a fully-connected layer. On start it latches the pooled pixel vector and fetches each neuron's 64-bit weight word from a synchronous weight ROM/RAM. It holds stable operands for the neuron and streams each result out with valid/ready. It also tracks the arg-max over the layer for classification.

---
 rtl/fc_neuron_sequencer_if.sv | 34 +++
 rtl/fc_neuron_sequencer.sv | 102 ++++++++++
 tb/tb_fc_neuron_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fc_neuron_sequencer_if.sv
// Handshake, weight-memory and neuron-operand bundle for fc_neuron_sequencer.
// The sequencer takes the slave view; the environment (memory, neuron, consumer) takes master.
interface fc_neuron_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic              start;
  logic [63:0]       pixel_in;
  logic              busy;
  logic              done;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic [63:0]       w_data;
  logic [63:0]       nrn_pixels;
  logic [63:0]       nrn_weight;
  logic [7:0]        nrn_result;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [7:0]        out_data;
  logic [ADDR_W-1:0] best_index;
  logic [7:0]        best_value;

  modport master (
    output start, pixel_in, w_data, nrn_result, out_ready,
    input  busy, done, w_rd_en, w_addr, nrn_pixels, nrn_weight,
           out_valid, out_index, out_data, best_index, best_value
  );

  modport slave (
    input  start, pixel_in, w_data, nrn_result, out_ready,
    output busy, done, w_rd_en, w_addr, nrn_pixels, nrn_weight,
           out_valid, out_index, out_data, best_index, best_value
  );
endinterface

// File: rtl/fc_neuron_sequencer.sv
// Time-multiplexes one registered 8-input FC neuron over NUM_NEURONS outputs,
// streaming each result with valid/ready and tracking the layer arg-max.
module fc_neuron_sequencer #(
  parameter int NUM_NEURONS = 10,
  parameter int ADDR_W      = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  fc_neuron_sequencer_if.slave  bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LOAD    = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_EMIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [63:0]       pixel_q;
  logic [63:0]       weight_q;
  logic [7:0]        max_val;
  logic [ADDR_W-1:0] max_idx;
  logic              first;
  logic [7:0]        best_val_q;
  logic [ADDR_W-1:0] best_idx_q;

  // NOTE: all state below uses non-blocking assignment so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= S_IDLE;
      cnt        <= '0;
      pixel_q    <= '0;
      weight_q   <= '0;
      max_val    <= '0;
      max_idx    <= '0;
      first      <= 1'b0;
      best_val_q <= '0;
      best_idx_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            pixel_q <= bus.pixel_in;
            cnt     <= '0;
            max_val <= '0;
            max_idx <= '0;
            first   <= 1'b1;
            state   <= S_FETCH;
          end
        end
        S_FETCH:   state <= S_LOAD;
        S_LOAD: begin
          weight_q <= bus.w_data;
          state    <= S_COMPUTE;
        end
        S_COMPUTE: state <= S_EMIT;
        S_EMIT: begin
          if (bus.out_ready) begin
            // Strict compare: on ties the lower neuron index wins.
            if (first || (bus.nrn_result > max_val)) begin
              max_val <= bus.nrn_result;
              max_idx <= cnt;
            end
            first <= 1'b0;
            if (cnt == LAST_IDX) begin
              state <= S_DONE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          best_val_q <= max_val;
          best_idx_q <= max_idx;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: outputs are pure continuous decodes of registered state, so no
  // path here can hold a value and infer a latch.
  assign bus.busy       = (state != S_IDLE);
  assign bus.done       = (state == S_DONE);
  assign bus.w_rd_en    = (state == S_FETCH);
  assign bus.w_addr     = cnt;
  assign bus.nrn_pixels = pixel_q;
  assign bus.nrn_weight = weight_q;
  assign bus.out_valid  = (state == S_EMIT);
  assign bus.out_index  = cnt;
  assign bus.out_data   = (state == S_EMIT) ? bus.nrn_result : 8'd0;
  assign bus.best_index = best_idx_q;
  assign bus.best_value = best_val_q;

endmodule

// File: tb/tb_fc_neuron_sequencer.sv
// Self-checking bench: a cycle-timed behavioural model of the layer run is
// compared with the 4-neuron sequencer every cycle; a 1-neuron copy is pinned by hand.
module tb_fc_neuron_sequencer;

  localparam int N4 = 4;
  localparam int AW = 4;

  logic clk    = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  fc_neuron_sequencer_if #(.ADDR_W(AW)) bus  ();
  fc_neuron_sequencer_if #(.ADDR_W(AW)) bus1 ();

  fc_neuron_sequencer #(.NUM_NEURONS(N4), .ADDR_W(AW)) dut (
    .clk(clk), .resetN(resetN), .bus(bus));
  fc_neuron_sequencer #(.NUM_NEURONS(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .resetN(resetN), .bus(bus1));

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mem [16];

  function automatic logic [7:0] dot(input logic [63:0] p, input logic [63:0] w);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'(p[8*i +: 8]) * int'(w[8*i +: 8]);
    return 8'(s);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Environment: synchronous weight memory and the registered neuron.
  always @(posedge clk) begin
    if (bus.w_rd_en)  bus.w_data  <= mem[bus.w_addr];
    if (bus1.w_rd_en) bus1.w_data <= mem[bus1.w_addr];
    bus.nrn_result  <= dot(bus.nrn_pixels,  bus.nrn_weight);
    bus1.nrn_result <= dot(bus1.nrn_pixels, bus1.nrn_weight);
  end

  // Reference model: a run is "3 cycles of preparation then an offer" per
  // neuron, an accepted offer advances, a one-cycle done follows the last.
  bit          m_busy = 0, m_valid = 0, m_done = 0;
  int          m_wait = 0, m_k = 0;
  logic [63:0] m_pix = '0;
  logic [7:0]  m_max_val = '0, m_best_val = '0;
  int          m_max_idx = 0, m_best_idx = 0;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_busy <= 0; m_valid <= 0; m_done <= 0; m_wait <= 0; m_k <= 0;
      m_pix <= '0; m_max_val <= '0; m_max_idx <= 0;
      m_best_val <= '0; m_best_idx <= 0;
    end else if (!m_busy) begin
      if (bus.start) begin
        m_busy <= 1; m_pix <= bus.pixel_in; m_k <= 0; m_wait <= 3;
        m_max_val <= '0; m_max_idx <= 0;
      end
    end else if (m_done) begin
      m_done <= 0; m_busy <= 0;
      m_best_val <= m_max_val; m_best_idx <= m_max_idx;
    end else if (m_valid) begin
      if (bus.out_ready) begin
        m_valid <= 0;
        if (m_k == 0 || dot(m_pix, mem[m_k]) > m_max_val) begin
          m_max_val <= dot(m_pix, mem[m_k]);
          m_max_idx <= m_k;
        end
        if (m_k == N4 - 1) m_done <= 1;
        else begin m_k <= m_k + 1; m_wait <= 3; end
      end
    end else if (m_wait == 1) m_valid <= 1;
    else m_wait <= m_wait - 1;
  end

  always @(negedge clk) begin : compare
    bit exp_rd;
    exp_rd = m_busy && !m_done && !m_valid && (m_wait == 3);
    check("busy",       64'(bus.busy),       64'(m_busy));
    check("done",       64'(bus.done),       64'(m_done));
    check("out_valid",  64'(bus.out_valid),  64'(m_valid));
    check("out_data",   64'(bus.out_data),   64'(m_valid ? dot(m_pix, mem[m_k]) : 8'd0));
    check("w_rd_en",    64'(bus.w_rd_en),    64'(exp_rd));
    check("nrn_pixels", bus.nrn_pixels,      m_pix);
    check("best_index", 64'(bus.best_index), 64'(m_best_idx));
    check("best_value", 64'(bus.best_value), 64'(m_best_val));
    if (m_valid) check("out_index", 64'(bus.out_index), 64'(m_k));
    if (exp_rd)  check("w_addr",    64'(bus.w_addr),    64'(m_k));
    if (m_valid || (m_busy && !m_done && m_wait == 1))
      check("nrn_weight", bus.nrn_weight, mem[m_k]);
  end

  int         cap_cyc [8];
  int         cap_idx [8];
  logic [7:0] cap_data[8];
  int         ncap, done_c;

  // One run on the 4-neuron DUT; logs accepted results with their cycle
  // numbers counted from the start-sampling edge.
  task automatic run(input logic [63:0] pix, input int stall_from,
                     input int stall_len, input bit noisy);
    int c;
    ncap = 0; done_c = -1;
    @(posedge clk); #1;
    bus.pixel_in = pix; bus.start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (c = 1; c < 400; c++) begin
      @(negedge clk);
      if (noisy) begin
        bus.start     = 1'($urandom_range(0, 1));
        bus.pixel_in  = {$urandom, $urandom};
        bus.out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.out_ready = !(c >= stall_from && c < stall_from + stall_len);
      end
      if (bus.out_valid && bus.out_ready && ncap < 8) begin
        cap_cyc[ncap] = c; cap_idx[ncap] = int'(bus.out_index);
        cap_data[ncap] = bus.out_data; ncap++;
      end
      if (bus.done) done_c = c;
      if (!bus.busy) break;
    end
    bus.start = 1'b0; bus.out_ready = 1'b1;
    check("run_terminates", 64'(c < 400), 64'(1));
  endtask

  initial begin
    bit got;
    int c1_valid, c1_done;
    logic [7:0] d1;
    bus.start = 0; bus.pixel_in = '0; bus.out_ready = 1;
    bus1.start = 0; bus1.pixel_in = '0; bus1.out_ready = 1;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    #1 resetN = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",   64'(bus.busy),       64'(0));
    check("rst_best_v", 64'(bus.best_value), 64'(0));
    resetN = 1'b1;

    // Basic run: pixels 1, weights k+1.
    for (int k = 0; k < N4; k++) mem[k] = {8{8'(k + 1)}};
    run({8{8'h01}}, 0, 0, 0);
    check("t1_count", 64'(ncap), 64'(4));
    for (int i = 0; i < 4; i++) begin
      check("t1_data",  64'(cap_data[i]), 64'(8 * (i + 1)));
      check("t1_cycle", 64'(cap_cyc[i]),  64'(4 * (i + 1)));
      check("t1_index", 64'(cap_idx[i]),  64'(i));
    end
    check("t1_done_cyc", 64'(done_c),          64'(17));
    check("t1_best_idx", 64'(bus.best_index),  64'(3));
    check("t1_best_val", 64'(bus.best_value),  64'(32));

    // Five-cycle stall while neuron 1 is offered.
    run({8{8'h01}}, 8, 5, 0);
    check("st_cycle1",   64'(cap_cyc[1]),  64'(13));
    check("st_data1",    64'(cap_data[1]), 64'(16));
    check("st_cycle3",   64'(cap_cyc[3]),  64'(21));
    check("st_done_cyc", 64'(done_c),      64'(22));

    // Truncating overflow and all-equal arg-max.
    for (int k = 0; k < N4; k++) mem[k] = {8{8'h01}};
    run({8{8'hFF}}, 0, 0, 0);
    for (int i = 0; i < 4; i++) check("ov_data", 64'(cap_data[i]), 64'(8'hF8));
    check("ov_best_idx", 64'(bus.best_index), 64'(0));
    check("ov_best_val", 64'(bus.best_value), 64'(8'hF8));

    // Reset while neuron 2 is being offered.
    for (int k = 0; k < N4; k++) mem[k] = {8{8'(k + 1)}};
    @(posedge clk); #1;
    bus.pixel_in = {8{8'h01}}; bus.start = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_index == 4'd2) begin
        bus.out_ready = 1'b0; got = 1;
      end else bus.out_ready = 1'b1;
    end
    check("rst_reached_emit2", 64'(got), 64'(1));
    #1 resetN = 1'b0;
    #1;
    check("ar_busy",      64'(bus.busy),       64'(0));
    check("ar_done",      64'(bus.done),       64'(0));
    check("ar_rd_en",     64'(bus.w_rd_en),    64'(0));
    check("ar_w_addr",    64'(bus.w_addr),     64'(0));
    check("ar_valid",     64'(bus.out_valid),  64'(0));
    check("ar_index",     64'(bus.out_index),  64'(0));
    check("ar_data",      64'(bus.out_data),   64'(0));
    check("ar_pixels",    bus.nrn_pixels,      64'(0));
    check("ar_weight",    bus.nrn_weight,      64'(0));
    check("ar_best_idx",  64'(bus.best_index), 64'(0));
    check("ar_best_val",  64'(bus.best_value), 64'(0));
    @(negedge clk);
    resetN = 1'b1; bus.out_ready = 1'b1;
    run({8{8'h01}}, 0, 0, 0);
    check("pr_count",    64'(ncap),        64'(4));
    check("pr_index0",   64'(cap_idx[0]),  64'(0));
    check("pr_data0",    64'(cap_data[0]), 64'(8));
    check("pr_done_cyc", 64'(done_c),      64'(17));

    // Single-neuron layer: pixels 2, weights 3 -> 48.
    mem[0] = {8{8'h03}};
    c1_valid = -1; c1_done = -1; d1 = '0;
    @(posedge clk); #1;
    bus1.pixel_in = {8{8'h02}}; bus1.start = 1'b1;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      if (bus1.out_valid && c1_valid < 0) begin c1_valid = c; d1 = bus1.out_data; end
      if (bus1.done) c1_done = c;
      if (!bus1.busy) break;
    end
    check("n1_valid_cyc", 64'(c1_valid),         64'(4));
    check("n1_data",      64'(d1),               64'(8'h30));
    check("n1_done_cyc",  64'(c1_done),          64'(5));
    check("n1_best_idx",  64'(bus1.best_index),  64'(0));
    check("n1_best_val",  64'(bus1.best_value),  64'(8'h30));

    // Randomised runs: random weights with forced ties, random ready,
    // start pulses and pixel changes while busy.
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N4; k++) begin
        mem[k] = {$urandom, $urandom};
        if (k > 0 && $urandom_range(0, 3) == 0) mem[k] = mem[0];
      end
      run({$urandom, $urandom}, 0, 0, 1);
      check("rnd_count", 64'(ncap), 64'(4));
      for (int i = 0; i < 4 && i < ncap; i++) check("rnd_order", 64'(cap_idx[i]), 64'(i));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
